// File: rtl/inst_recorder.sv
// Instruction recorder: captures switch values on button edges, then replays them one at a time
// to an external controller with a valid/done handshake.
module inst_recorder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          mode,
  input  logic          wr_btn,
  input  logic          clr_btn,
  input  logic [7:0]    sw,
  input  logic          inst_done,
  output logic [7:0]    inst,
  output logic          inst_valid,
  output logic          prog_done,
  output logic [AW:0]   count,
  output logic          full
);

  typedef enum logic [1:0] {StRec, StFetch, StIssue, StDone} state_e;

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  state_e         state_q;
  logic [AW-1:0]  pc_q;
  logic [AW:0]    count_q;
  logic [7:0]     inst_q;
  logic           inst_valid_q;
  logic           prog_done_q;
  logic           wr_prev_q;
  logic           clr_prev_q;
  logic [7:0]     mem_q [DEPTH];

  logic wr_edge;
  logic clr_edge;
  logic mem_we;
  logic at_last;

  assign wr_edge  = wr_btn & ~wr_prev_q;
  assign clr_edge = clr_btn & ~clr_prev_q;
  assign full     = (count_q == DepthCnt);
  // Clear beats a coincident write; a full buffer swallows further writes.
  assign mem_we   = (state_q == StRec) & wr_edge & ~clr_edge & ~full;
  assign at_last  = ({1'b0, pc_q} == (count_q - (AW+1)'(1)));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= StRec;
      pc_q         <= '0;
      count_q      <= '0;
      inst_q       <= 8'h00;
      inst_valid_q <= 1'b0;
      prog_done_q  <= 1'b0;
      wr_prev_q    <= 1'b0;
      clr_prev_q   <= 1'b0;
    end else begin
      wr_prev_q  <= wr_btn;
      clr_prev_q <= clr_btn;
      unique case (state_q)
        StRec: begin
          if (clr_edge) begin
            count_q <= '0;
          end else if (mem_we) begin
            count_q <= count_q + (AW+1)'(1);
          end
          if (mode) begin
            pc_q <= '0;
            if (count_q != '0) begin
              state_q <= StFetch;
            end else begin
              state_q     <= StDone;
              prog_done_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (!mode) begin
            state_q <= StRec;
          end else begin
            inst_q       <= mem_q[pc_q];
            inst_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (!mode) begin
            inst_valid_q <= 1'b0;
            state_q      <= StRec;
          end else if (inst_done) begin
            inst_valid_q <= 1'b0;
            if (at_last) begin
              prog_done_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              pc_q    <= pc_q + AW'(1);
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          if (!mode) begin
            prog_done_q <= 1'b0;
            state_q     <= StRec;
          end
        end
        default: state_q <= StRec;
      endcase
    end
  end

  // Storage is deliberately unreset; only written slots are ever read back.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[AW-1:0]] <= sw;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign prog_done  = prog_done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_recorder.sv
// Directed bench for inst_recorder: record, playback, overflow, clear, abort and async reset.
module tb_inst_recorder;

  logic       clk = 1'b0;
  logic       clr;
  logic       mode;
  logic       wr_btn;
  logic       clr_btn;
  logic [7:0] sw;
  logic       inst_done;
  logic [7:0] inst;
  logic       inst_valid;
  logic       prog_done;
  logic [4:0] count;
  logic       full;

  int passed = 0;
  int total  = 0;

  inst_recorder #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .mode       (mode),
    .wr_btn     (wr_btn),
    .clr_btn    (clr_btn),
    .sw         (sw),
    .inst_done  (inst_done),
    .inst       (inst),
    .inst_valid (inst_valid),
    .prog_done  (prog_done),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press_wr(input logic [7:0] v);
    sw     = v;
    wr_btn = 1'b1;
    @(negedge clk);
    wr_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_clr();
    clr_btn = 1'b1;
    @(negedge clk);
    clr_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(inst_valid), 32'd1);
  endtask

  // Acts as the controller: executes for 3 cycles, then pulses inst_done.
  task automatic play_one(input logic [7:0] exp);
    wait_valid();
    chk("inst", 32'(inst), 32'(exp));
    repeat (3) @(negedge clk);
    chk("inst_stable", 32'(inst), 32'(exp));
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
  endtask

  initial begin
    clr = 1'b0; mode = 1'b0; wr_btn = 1'b0; clr_btn = 1'b0; sw = 8'h00; inst_done = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_inst", 32'(inst), 32'h00);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pdone", 32'(prog_done), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Basic record and playback of three instructions.
    press_wr(8'h12);
    press_wr(8'h34);
    press_wr(8'h56);
    chk("rec3_count", 32'(count), 32'd3);
    mode = 1'b1;
    @(negedge clk);
    chk("fetch_valid0", 32'(inst_valid), 32'd0);
    play_one(8'h12);
    chk("between_valid0", 32'(inst_valid), 32'd0);
    chk("between_pdone0", 32'(prog_done), 32'd0);
    play_one(8'h34);
    play_one(8'h56);
    chk("p3_pdone", 32'(prog_done), 32'd1);
    chk("p3_valid", 32'(inst_valid), 32'd0);
    chk("p3_count", 32'(count), 32'd3);
    mode = 1'b0;
    @(negedge clk);
    chk("rec_pdone0", 32'(prog_done), 32'd0);
    chk("rec_count_kept", 32'(count), 32'd3);

    // Fill to capacity, then one overflow write.
    press_clr();
    chk("clr_count", 32'(count), 32'd0);
    for (int i = 0; i < 16; i++) press_wr(8'(i + 1));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    press_wr(8'hAA);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    mode = 1'b1;
    for (int i = 0; i < 16; i++) play_one(8'(i + 1));
    chk("fill_pdone", 32'(prog_done), 32'd1);
    mode = 1'b0;
    @(negedge clk);

    // Clear coinciding with write: clear wins.
    press_clr();
    for (int i = 0; i < 5; i++) press_wr(8'h20 + 8'(i));
    chk("five_count", 32'(count), 32'd5);
    sw = 8'hFF; wr_btn = 1'b1; clr_btn = 1'b1;
    @(negedge clk);
    wr_btn = 1'b0; clr_btn = 1'b0;
    @(negedge clk);
    chk("both_count", 32'(count), 32'd0);
    chk("both_full", 32'(full), 32'd0);
    mode = 1'b1;
    @(negedge clk);
    chk("empty_pdone", 32'(prog_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("empty_valid0", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    mode = 1'b0;
    @(negedge clk);

    // Abort playback at pc 2 of 4, then restart from the beginning.
    press_wr(8'hA0);
    press_wr(8'hA1);
    press_wr(8'hA2);
    press_wr(8'hA3);
    mode = 1'b1;
    play_one(8'hA0);
    play_one(8'hA1);
    wait_valid();
    chk("abort_inst", 32'(inst), 32'hA2);
    mode = 1'b0;
    @(negedge clk);
    chk("abort_valid0", 32'(inst_valid), 32'd0);
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    @(negedge clk);
    chk("abort_valid_still0", 32'(inst_valid), 32'd0);
    chk("abort_pdone0", 32'(prog_done), 32'd0);
    chk("abort_count", 32'(count), 32'd4);
    mode = 1'b1;
    play_one(8'hA0);
    play_one(8'hA1);
    play_one(8'hA2);
    play_one(8'hA3);
    chk("restart_pdone", 32'(prog_done), 32'd1);

    // inst_done in DONE is ignored.
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    @(negedge clk);
    chk("done_hold_pdone", 32'(prog_done), 32'd1);
    chk("done_hold_valid", 32'(inst_valid), 32'd0);
    mode = 1'b0;
    @(negedge clk);

    // inst_done in FETCH is ignored: first instruction must still be issued and held.
    press_clr();
    press_wr(8'h5A);
    press_wr(8'hC3);
    mode = 1'b1;
    @(negedge clk);
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    chk("fetch_done_valid", 32'(inst_valid), 32'd1);
    chk("fetch_done_inst", 32'(inst), 32'h5A);
    @(negedge clk);
    chk("fetch_done_held", 32'(inst_valid), 32'd1);
    play_one(8'h5A);
    play_one(8'hC3);
    chk("two_pdone", 32'(prog_done), 32'd1);
    mode = 1'b0;
    @(negedge clk);

    // Held button produces a single write.
    press_clr();
    sw = 8'h77;
    wr_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sw = 8'h70 + 8'(i);
    end
    wr_btn = 1'b0;
    @(negedge clk);
    chk("held_count", 32'(count), 32'd1);
    mode = 1'b1;
    play_one(8'h77);
    chk("held_pdone", 32'(prog_done), 32'd1);
    mode = 1'b0;
    @(negedge clk);

    // Asynchronous reset between edges during ISSUE.
    press_wr(8'h99);
    mode = 1'b1;
    wait_valid();
    #1 clr = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_inst", 32'(inst), 32'h00);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("post_rst_pdone", 32'(prog_done), 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    #1 clr = 1'b0;
    #1;
    chk("async_pdone", 32'(prog_done), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    mode = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_recorder.md
INST_RECORDER -- requirements
Module: inst_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 8-bit instruction slots (power of two).
REQ-002 SHALL have parameter AW, default 4, meaning address width, log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port clr, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port mode, input, 1, 0 = record, 1 = play.
REQ-006 SHALL have port wr_btn, input, 1, debounced level; a rising edge stores sw.
REQ-007 SHALL have port clr_btn, input, 1, debounced level; a rising edge erases the program.
REQ-008 SHALL have port sw, input, 8, instruction to record.
REQ-009 SHALL have port inst_done, input, 1, one-cycle pulse from the controller: current instruction finished.
REQ-010 SHALL have port inst, output, 8, instruction presented to the controller.
REQ-011 SHALL have port inst_valid, output, 1, inst is valid for execution.
REQ-012 SHALL have port prog_done, output, 1, playback finished.
REQ-013 SHALL have port count, output, AW+1, number of stored instructions.
REQ-014 SHALL have port full, output, 1, high when count == DEPTH.

Function
REQ-015 SHALL implement a 4-state FSM: REC, FETCH, ISSUE, DONE.
REQ-016 SHALL detect rising edges of wr_btn and clr_btn with internal one-cycle-delayed copies; an edge is registered level high and previous low.
REQ-017 In REC, a wr_btn edge with count < DEPTH SHALL write sw to mem[count[AW-1:0]] and increment count at the same clock edge.
REQ-018 In REC, a wr_btn edge with full = 1 SHALL be ignored; count, memory and full stay unchanged.
REQ-019 In REC, a clr_btn edge SHALL set count to 0; if it coincides with a wr_btn edge, clear wins and nothing is written.
REQ-020 full SHALL be combinational from count (count == DEPTH).
REQ-021 In REC with mode = 1, the FSM SHALL set pc to 0 and go to FETCH if count > 0, otherwise go directly to DONE.
REQ-022 FETCH SHALL load inst <= mem[pc] and go to ISSUE; inst_valid SHALL be 0 in FETCH.
REQ-023 In ISSUE, inst_valid SHALL be 1 and inst SHALL be held stable until inst_done.
REQ-024 On inst_done in ISSUE: if pc == count-1, go to DONE; otherwise increment pc and go to FETCH. Each instruction takes 1 idle cycle plus the controller's execution time.
REQ-025 inst_done outside ISSUE SHALL be ignored.
REQ-026 In DONE, prog_done SHALL be 1 and inst_valid 0; the FSM SHALL stay in DONE while mode = 1.
REQ-027 In FETCH, ISSUE or DONE, mode = 0 SHALL return the FSM to REC on the next edge (aborting any playback) and clear inst_valid and prog_done. count and memory are retained.
REQ-028 wr_btn and clr_btn edges outside REC SHALL be ignored.
REQ-029 Memory SHALL be a DEPTH x 8 register array with synchronous write and no reset. Unwritten contents are never presented.

Reset
REQ-030 While clr = 0, outputs and state SHALL be: state REC, pc 0, count 0, full 0, inst 8'h00, inst_valid 0, prog_done 0, and edge-detect registers 0, all asynchronously.
REQ-031 Reset asserted mid-playback SHALL abort immediately. After release the block SHALL be in REC with an empty program, even if mode = 1; it then follows REQ-021 on the next edge.

Verification
REQ-032 With mode 0, record sw = 8'h12, 8'h34, 8'h56 via 3 wr_btn edges, then set mode 1 and pulse inst_done 3 cycles after each inst_valid rise -> inst shows 12, 34, 56 in order; prog_done = 1 after the third inst_done; count = 3.
REQ-033 Apply 17 wr_btn edges -> count = 16 and full = 1 after the 16th edge; the 17th edge leaves mem[0] and count unchanged; playback shows the first 16 values.
REQ-034 With count = 5, raise wr_btn and clr_btn on the same edge -> count = 0 and no write occurs; then mode 1 -> DONE next cycle, prog_done = 1, inst_valid never 1.
REQ-035 During playback at pc = 2 of 4, drop mode to 0 -> inst_valid = 0 next cycle; a later inst_done has no effect. Mode 1 again -> restarts at mem[0].
REQ-036 Pulse inst_done in FETCH and DONE, and hold wr_btn high for 10 cycles in REC -> no state change from inst_done; exactly one write from the held button.
REQ-037 Drive clr low between clock edges during ISSUE -> inst_valid, prog_done and count drop to 0 without waiting for clk.
